// File: rtl/mealy_mod_stepper_if.sv
// Control/status bundle for mealy_mod_stepper: controller drives the
// step controls, the stepper returns tick, state and the decoded display.
interface mealy_mod_stepper_if #(
    parameter int unsigned STATE_W = 4
);
    logic               en;
    logic               dir;
    logic               in;
    logic               load;
    logic [STATE_W-1:0] load_val;
    logic               tick;
    logic [STATE_W-1:0] state_q;
    logic               wrap;
    logic [STATE_W-1:0] mealy_val;
    logic [6:0]         seg;

    modport master (
        output en, dir, in, load, load_val,
        input  tick, state_q, wrap, mealy_val, seg
    );

    modport slave (
        input  en, dir, in, load, load_val,
        output tick, state_q, wrap, mealy_val, seg
    );
endinterface

// File: rtl/mealy_mod_stepper.sv
// Modulo up/down stepper advanced by a clock-enable prescaler; Mealy output
// gated by the synchronised input and shown on an active-low 7-seg decoder.
module mealy_mod_stepper #(
    parameter int unsigned MODULUS   = 6,
    parameter int unsigned STEP0     = 1,
    parameter int unsigned STEP1     = 3,
    parameter int unsigned DIV_COUNT = 25000000,
    parameter int unsigned STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mealy_mod_stepper_if.slave   bus
);
    localparam int unsigned CNT_W = (DIV_COUNT < 1) ? 1 : $clog2(DIV_COUNT + 1);
    localparam int unsigned AW    = STATE_W + 1;

    localparam logic [CNT_W-1:0]   CNT_TC  = CNT_W'(DIV_COUNT);
    localparam logic [AW-1:0]      MOD_A   = AW'(MODULUS);
    localparam logic [AW-1:0]      STEP0_A = AW'(STEP0);
    localparam logic [AW-1:0]      STEP1_A = AW'(STEP1);
    localparam logic [STATE_W-1:0] MAX_S   = STATE_W'(MODULUS - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_tick;
    logic               r_sync1;
    logic               r_sync2;
    logic [STATE_W-1:0] r_state;
    logic               r_wrap;

    logic               w_in_s;
    logic [AW-1:0]      w_cur;
    logic [AW-1:0]      w_step;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_diff;
    logic [STATE_W-1:0] w_next;
    logic               w_next_wrap;
    logic [STATE_W-1:0] w_load_clamped;
    logic [STATE_W-1:0] w_mealy;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg;

    assign w_in_s = r_sync2;

    // Prescaler: tick is a one-cycle pulse after the terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (bus.en) begin
            if (r_cnt == CNT_TC) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.in;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state arithmetic one bit wider than the state so MODULUS=16 fits
    always_comb begin
        w_cur       = {1'b0, r_state};
        w_step      = w_in_s ? STEP1_A : STEP0_A;
        w_sum       = w_cur + w_step;
        w_diff      = w_cur + MOD_A - w_step;
        w_next      = r_state;
        w_next_wrap = 1'b0;
        if (!bus.dir) begin
            if (w_sum >= MOD_A) begin
                w_next      = STATE_W'(w_sum - MOD_A);
                w_next_wrap = 1'b1;
            end else begin
                w_next      = STATE_W'(w_sum);
            end
        end else begin
            if (w_cur < w_step) begin
                w_next      = STATE_W'(w_diff);
                w_next_wrap = 1'b1;
            end else begin
                w_next      = STATE_W'(w_cur - w_step);
            end
        end
    end

    assign w_load_clamped = ({1'b0, bus.load_val} >= MOD_A) ? MAX_S : bus.load_val;

    // Load wins over a coincident tick and never reports a wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.load) begin
            r_state <= w_load_clamped;
            r_wrap  <= 1'b0;
        end else if (r_tick && bus.en) begin
            r_state <= w_next;
            r_wrap  <= w_next_wrap;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign w_mealy = w_in_s ? r_state : '0;
    assign w_digit = 4'(w_mealy);

    // Active-low segments {a,b,c,d,e,f,g}
    always_comb begin
        w_seg = 7'b1111111;
        case (w_digit)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            4'hF: w_seg = 7'b0111000;
            default: w_seg = 7'b1111111;
        endcase
    end

    assign bus.tick      = r_tick;
    assign bus.state_q   = r_state;
    assign bus.wrap      = r_wrap;
    assign bus.mealy_val = w_mealy;
    assign bus.seg       = w_seg;
endmodule

// File: tb/tb_mealy_mod_stepper.sv
// Directed bench for mealy_mod_stepper with DIV_COUNT=3 (tick every 4 clks).
module tb_mealy_mod_stepper;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mealy_mod_stepper_if #(.STATE_W(4)) bus ();

    mealy_mod_stepper #(
        .MODULUS(6), .STEP0(1), .STEP1(3), .DIV_COUNT(3), .STATE_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dir;
        logic       in_v;
        logic [3:0] st;
        logic       wr;
        logic [3:0] mv;
        logic [6:0] sg;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick_wait(input string nm);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.tick) begin
                found = 1;
                break;
            end
        end
        chk({nm, "_tick_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 7'b0000001};
        vecs[1]  = '{1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 7'b0000001};
        vecs[2]  = '{1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 7'b0000001};
        vecs[3]  = '{1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 7'b0000001};
        vecs[4]  = '{1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 7'b0000001};
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 7'b0000001};
        vecs[6]  = '{1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 7'b0000110};
        vecs[7]  = '{1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 7'b0000001};
        vecs[8]  = '{1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 7'b0000110};
        vecs[9]  = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 7'b0000001};
        vecs[10] = '{1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 7'b0000001};
        vecs[11] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 7'b0000001};
        vecs[12] = '{1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 7'b0000001};
        vecs[13] = '{1'b1, 1'b0, 4'd4, 1'b0, 4'd0, 7'b0000001};
        vecs[14] = '{1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 7'b0000001};
        vecs[15] = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 7'b0000001};
        vecs[16] = '{1'b1, 1'b1, 4'd5, 1'b1, 4'd5, 7'b0100100};
        vecs[17] = '{1'b1, 1'b1, 4'd2, 1'b0, 4'd2, 7'b0010010};

        bus.en = 1'b0; bus.dir = 1'b0; bus.in = 1'b0;
        bus.load = 1'b0; bus.load_val = 4'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state_q), 32'd0);
        chk("rst_tick",  32'(bus.tick), 32'd0);
        chk("rst_wrap",  32'(bus.wrap), 32'd0);
        chk("rst_mealy", 32'(bus.mealy_val), 32'd0);
        chk("rst_seg",   32'(bus.seg), 32'b0000001);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        bus.en = 1'b1;

        // Table: each entry is one tick-driven step
        for (int v = 0; v < NV; v++) begin
            bus.dir = vecs[v].dir;
            bus.in  = vecs[v].in_v;
            tick_wait($sformatf("v%0d", v));
            @(posedge clk); #1;
            chk($sformatf("v%0d_state", v), 32'(bus.state_q), 32'(vecs[v].st));
            chk($sformatf("v%0d_wrap", v),  32'(bus.wrap), 32'(vecs[v].wr));
            chk($sformatf("v%0d_mealy", v), 32'(bus.mealy_val), 32'(vecs[v].mv));
            chk($sformatf("v%0d_seg", v),   32'(bus.seg), 32'(vecs[v].sg));
            @(posedge clk); #1;
            chk($sformatf("v%0d_wrap_clr", v), 32'(bus.wrap), 32'd0);
            chk($sformatf("v%0d_tick_clr", v), 32'(bus.tick), 32'd0);
        end

        // Enable freeze mid-period (prescaler count is 2 here)
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("frz%0d_tick", i),  32'(bus.tick), 32'd0);
            chk($sformatf("frz%0d_state", i), 32'(bus.state_q), 32'd2);
        end
        bus.en = 1'b1;
        @(posedge clk); #1;
        chk("resume_tick0", 32'(bus.tick), 32'd0);
        @(posedge clk); #1;
        chk("resume_tick1", 32'(bus.tick), 32'd1);
        @(posedge clk); #1;
        chk("resume_state", 32'(bus.state_q), 32'd5);
        chk("resume_wrap",  32'(bus.wrap), 32'd1);

        // Input synchroniser latency with state frozen at 5
        bus.en = 1'b0; bus.dir = 1'b0; bus.in = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("sync_low", 32'(bus.mealy_val), 32'd0);
        bus.in = 1'b1;
        @(posedge clk); #1;
        chk("sync_1clk", 32'(bus.mealy_val), 32'd0);
        @(posedge clk); #1;
        chk("sync_2clk", 32'(bus.mealy_val), 32'd5);
        chk("sync_seg",  32'(bus.seg), 32'b0100100);

        // Load clamp while disabled
        bus.load = 1'b1; bus.load_val = 4'd9; bus.in = 1'b0;
        @(posedge clk); #1;
        chk("clamp_state", 32'(bus.state_q), 32'd5);
        chk("clamp_wrap",  32'(bus.wrap), 32'd0);
        bus.load = 1'b0;
        @(posedge clk); #1;

        // Load coincident with tick: step would give 0 with wrap
        bus.en = 1'b1;
        tick_wait("coinc");
        bus.load = 1'b1; bus.load_val = 4'd2;
        @(posedge clk); #1;
        chk("coinc_state", 32'(bus.state_q), 32'd2);
        chk("coinc_wrap",  32'(bus.wrap), 32'd0);
        bus.load = 1'b0;
        @(posedge clk); #1;
        chk("presc_t1", 32'(bus.tick), 32'd0);
        @(posedge clk); #1;
        chk("presc_t2", 32'(bus.tick), 32'd0);
        @(posedge clk); #1;
        chk("presc_t3", 32'(bus.tick), 32'd1);
        @(posedge clk); #1;
        chk("presc_state", 32'(bus.state_q), 32'd3);

        // Async reset between edges with state=4, in_s=1
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd4; bus.in = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        chk("pre_rst_state", 32'(bus.state_q), 32'd4);
        @(posedge clk); #1;
        chk("pre_rst_mealy", 32'(bus.mealy_val), 32'd4);
        chk("pre_rst_seg",   32'(bus.seg), 32'b1001100);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state_q), 32'd0);
        chk("arst_mealy", 32'(bus.mealy_val), 32'd0);
        chk("arst_seg",   32'(bus.seg), 32'b0000001);
        chk("arst_tick",  32'(bus.tick), 32'd0);
        chk("arst_wrap",  32'(bus.wrap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
